// File: rtl/disp_scan_mux.sv
// Multiplexed hex-digit display scanner: free-running slot divider, per-digit scan,
// tear-free double-buffered value update at frame wrap, optional leading-zero blanking.
module disp_scan_mux #(
  parameter int NDIGIT   = 4,
  parameter int CLKDIV   = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*NDIGIT-1:0]   value,
  input  logic [NDIGIT-1:0]     dp_in,
  output logic [7:0]            led,
  output logic [NDIGIT-1:0]     sel,
  output logic                  frame_done
);

  localparam int DW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
  localparam int IW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;

  logic [DW-1:0]          div;
  logic [IW-1:0]          idx;
  logic [4*NDIGIT-1:0]    pend_val, disp_val;
  logic [NDIGIT-1:0]      pend_dp, disp_dp;
  logic                   pend_flag;

  logic                   div_tc, wrap;
  logic [NDIGIT-1:0]      blank;
  logic [3:0]             cur_hex;
  logic [7:0]             led_nxt;
  logic [NDIGIT-1:0]      sel_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 7'b1111110;
      4'h1: seg7 = 7'b0110000;
      4'h2: seg7 = 7'b1101101;
      4'h3: seg7 = 7'b1111001;
      4'h4: seg7 = 7'b0110011;
      4'h5: seg7 = 7'b1011011;
      4'h6: seg7 = 7'b1011111;
      4'h7: seg7 = 7'b1110000;
      4'h8: seg7 = 7'b1111111;
      4'h9: seg7 = 7'b1111011;
      4'hA: seg7 = 7'b1110111;
      4'hB: seg7 = 7'b0011111;
      4'hC: seg7 = 7'b0001101;
      4'hD: seg7 = 7'b0111101;
      4'hE: seg7 = 7'b1001111;
      default: seg7 = 7'b1000111;
    endcase
  endfunction

  assign div_tc = (div == DW'(CLKDIV - 1));
  assign wrap   = div_tc && (idx == IW'(NDIGIT - 1));

  // A digit is blanked when it and every more-significant digit are zero.
  always_comb begin
    logic acc;
    acc   = 1'b0;
    blank = '0;
    for (int i = NDIGIT - 1; i >= 0; i--) begin
      acc = acc | (|disp_val[4*i +: 4]);
      blank[i] = (BLANK_LZ != 0) && (i > 0) && !acc;
    end
  end

  always_comb begin
    cur_hex = disp_val[4*int'(idx) +: 4];
    led_nxt = {blank[idx] ? 7'b0 : seg7(cur_hex), disp_dp[idx]};
    sel_nxt = NDIGIT'(1) << idx;
    if (!enable) begin
      led_nxt = '0;
      sel_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= '0;
    end else begin
      div <= div_tc ? '0 : div + DW'(1);
      if (div_tc) idx <= (idx == IW'(NDIGIT - 1)) ? '0 : idx + IW'(1);
    end
  end

  // Display only changes at frame wrap; a load on the wrap edge stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      disp_val  <= '0;
      disp_dp   <= '0;
    end else begin
      if (wrap && pend_flag) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
      if (load) begin
        pend_val  <= value;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end else if (wrap) begin
        pend_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led        <= '0;
      sel        <= '0;
      frame_done <= 1'b0;
    end else begin
      led        <= led_nxt;
      sel        <= sel_nxt;
      frame_done <= wrap;
    end
  end

endmodule

// File: doc/disp_scan_mux.md
DISP_SCAN_MUX -- requirements
Module: disp_scan_mux

Interface
REQ-001 SHALL have parameter NDIGIT, default 4: number of multiplexed hex digits (1..8).
REQ-002 SHALL have parameter CLKDIV, default 1000: clock cycles per digit slot (>=2).
REQ-003 SHALL have parameter BLANK_LZ, default 1: 1 = leading-zero blanking enabled.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-006 SHALL have port enable  input  1  1 = drive display; 0 = led/sel forced to 0.
REQ-007 SHALL have port load  input  1  one-cycle strobe; captures value/dp_in.
REQ-008 SHALL have port value  input  4*NDIGIT  hex digits; digit i = value[4i+3:4i], digit 0 least significant.
REQ-009 SHALL have port dp_in  input  NDIGIT  decimal point per digit, active-high.
REQ-010 SHALL have port led  output  8  segments {a,b,c,d,e,f,g,dp}, MSB = a, active-high, registered.
REQ-011 SHALL have port sel  output  NDIGIT  one-hot digit select, active-high, registered.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-013 SHALL decode 0-F as: 0 11111100, 1 01100000, 2 11011010, 3 11110010, 4 01100110, 5 10110110, 6 10111110, 7 11100000, 8 11111110, 9 11110110, A 11101110, b 00111110, c 00011010, d 01111010, E 10011110, F 10001110 (dp bit 0).
REQ-014 SHALL keep divider div counting 0..CLKDIV-1, wrapping to 0; runs regardless of enable.
REQ-015 SHALL advance digit index idx by 1 on each edge where div==CLKDIV-1; idx wraps NDIGIT-1 -> 0.
REQ-016 SHALL assert frame_done for exactly the one cycle following the edge on which idx wraps to 0.
REQ-017 SHALL on load=1 capture value and dp_in into a pending register and set pending flag; a load while pending overwrites the pending data.
REQ-018 SHALL copy pending into the display register and clear pending flag on the idx-wrap edge only (tear-free update); load on that same edge is captured into pending and remains pending (not displayed until next wrap).
REQ-019 SHALL, on every edge, register sel = one-hot(idx) and led = segments of display digit idx with dp bit = display dp[idx]; outputs lag idx by one cycle.
REQ-020 SHALL, when BLANK_LZ=1, blank digit i (segment bits a-g = 0) if i>0 and all display digits i..NDIGIT-1 are 0; digit 0 never blanked; dp bit unaffected by blanking.
REQ-021 SHALL, when enable=0, register led=0 and sel=0; counters, pending and display registers continue to operate.
REQ-022 SHALL guarantee sel has at most one bit set in every cycle.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force div=0, idx=0, display value/dp=0, pending data/flag=0, led=0, sel=0, frame_done=0.
REQ-024 SHALL, on first edge after rst_n rises with enable=1, output sel=digit 0 and led=11111100 (displayed value 0).
REQ-025 SHALL, on reset asserted mid-frame or with load pending, discard pending data; no partial update survives.

Verification (NDIGIT=4, CLKDIV=4, BLANK_LZ=1 unless stated)
REQ-026 SHALL cover scan: after reset, enable=1 -> sel sequence 0001,0010,0100,1000 each held 4 cycles, repeating; frame_done pulses every 16 cycles.
REQ-027 SHALL cover update+blanking: load value=16'h00A5, dp_in=4'b0100 mid-frame -> old value held until wrap; next frame digit3 led=00000000, digit2 00000001, digit1 11101110, digit0 10110110.
REQ-028 SHALL cover decode: load each of 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF with BLANK_LZ=0 -> every digit matches REQ-013 table (9 = 11110110, digit 3 of 0123 = 11111100).
REQ-029 SHALL cover load collision: load 16'h1111 then 16'h2222 before wrap, then load 16'h3333 on wrap edge -> next frame shows 2222; frame after shows 3333.
REQ-030 SHALL cover enable: enable=0 for 10 cycles mid-frame -> led=0, sel=0 next cycle; on re-enable sel resumes at the idx the free-running counters reached.
REQ-031 SHALL cover reset mid-operation: assert rst_n=0 with load pending at idx=2 -> led, sel, frame_done 0 immediately; after release digit 0 shows 11111100, pending discarded.
